ff_bank_arbiter: RTL and testbench

- Shares one bank of N_CELLS flip-flop cells between two command requesters, A and B.
- Each cell can be loaded like a D flip-flop, toggled like a T flip-flop, or written in bulk.
- Round-robin arbitration with an optional bounded lock lets one requester own the bank for a short burst.
- Sits between control logic and the storage bank; owns both the storage and the sequencing.

---
 rtl/ff_bank_pkg.sv | 15 +
 rtl/ff_bank_arbiter_cells.sv | 53 +++++
 rtl/ff_bank_arbiter.sv | 150 +++++++++++++++
 tb/tb_ff_bank_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// Shared opcode and FSM state encodings for the two-requester flip-flop bank.
package ff_bank_pkg;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_BCAST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

endpackage

// File: rtl/ff_bank_arbiter_cells.sv
// Storage bank: applies one muxed command per cycle to N_CELLS flip-flop cells.
module ff_bank_cells
  import ff_bank_pkg::*;
#(
  parameter int N_CELLS = 8,
  parameter int ADDR_W  = $clog2(N_CELLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         op,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               data,
  output logic [N_CELLS-1:0] q,
  output logic [N_CELLS-1:0] q_bar,
  output logic               err
);

  logic [N_CELLS-1:0] q_reg;
  logic [N_CELLS-1:0] q_next;
  logic               err_reg;
  logic               in_range;

  assign in_range = int'(addr) < N_CELLS;

  // An out-of-range address matches no cell, so LOAD/TOGGLE leave q untouched.
  generate
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
      logic hit;
      assign hit = (addr == ADDR_W'(gi));
      assign q_next[gi] = (op == OP_CLEAR) ? 1'b0 :
                          (op == OP_BCAST) ? data :
                          !hit             ? q_reg[gi] :
                          (op == OP_LOAD)  ? data :
                                             (q_reg[gi] ^ data);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= '0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= en && ((op == OP_LOAD) || (op == OP_TOGGLE)) && !in_range;
      if (en) q_reg <= q_next;
    end
  end

  assign q     = q_reg;
  assign q_bar = ~q_reg;
  assign err   = err_reg;

endmodule

// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter with bounded lock sharing one flip-flop bank between requesters A and B.
module ff_bank_arbiter
  import ff_bank_pkg::*;
#(
  parameter int N_CELLS  = 8,
  parameter int ADDR_W   = $clog2(N_CELLS),
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [1:0]         a_op,
  input  logic [ADDR_W-1:0]  a_addr,
  input  logic               a_data,
  input  logic               a_lock,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [1:0]         b_op,
  input  logic [ADDR_W-1:0]  b_addr,
  input  logic               b_data,
  input  logic               b_lock,
  output logic [N_CELLS-1:0] q,
  output logic [N_CELLS-1:0] q_bar,
  output logic               last_grant,
  output logic               busy,
  output logic               err
);

  localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
  localparam bit LOCK_EN = (MAX_HOLD > 1);

  state_t            state_reg;
  logic              last_grant_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_inc;
  logic              hold_max;
  logic              a_acc;
  logic              b_acc;

  logic              cmd_en;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_data;

  // Ready depends only on state, valids and last_grant, never on payload.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: begin
          a_ready = a_valid && (!b_valid || last_grant_reg);
          b_ready = b_valid && (!a_valid || !last_grant_reg);
        end
        ST_OWN_A: a_ready = a_valid;
        ST_OWN_B: b_ready = b_valid;
        default: ;
      endcase
    end
  end

  assign a_acc    = a_valid && a_ready;
  assign b_acc    = b_valid && b_ready;
  assign hold_inc = hold_cnt_reg + 1'b1;
  assign hold_max = (hold_inc == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      hold_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (a_acc) begin
            last_grant_reg <= 1'b0;
            if (a_lock && LOCK_EN) begin
              state_reg    <= ST_OWN_A;
              hold_cnt_reg <= HOLD_W'(1);
            end
          end else if (b_acc) begin
            last_grant_reg <= 1'b1;
            if (b_lock && LOCK_EN) begin
              state_reg    <= ST_OWN_B;
              hold_cnt_reg <= HOLD_W'(1);
            end
          end
        end
        ST_OWN_A: begin
          if (!a_valid) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
          end else begin
            last_grant_reg <= 1'b0;
            if (!a_lock || hold_max) begin
              state_reg    <= ST_IDLE;
              hold_cnt_reg <= '0;
            end else begin
              hold_cnt_reg <= hold_inc;
            end
          end
        end
        ST_OWN_B: begin
          if (!b_valid) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
          end else begin
            last_grant_reg <= 1'b1;
            if (!b_lock || hold_max) begin
              state_reg    <= ST_IDLE;
              hold_cnt_reg <= '0;
            end else begin
              hold_cnt_reg <= hold_inc;
            end
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          hold_cnt_reg <= '0;
        end
      endcase
    end
  end

  // At most one ready is high, so the accepted requester selects the payload.
  assign cmd_en   = a_acc || b_acc;
  assign cmd_op   = b_acc ? b_op   : a_op;
  assign cmd_addr = b_acc ? b_addr : a_addr;
  assign cmd_data = b_acc ? b_data : a_data;

  ff_bank_cells #(
    .N_CELLS(N_CELLS),
    .ADDR_W (ADDR_W)
  ) u_cells (
    .clk  (clk),
    .rst  (rst),
    .en   (cmd_en),
    .op   (cmd_op),
    .addr (cmd_addr),
    .data (cmd_data),
    .q    (q),
    .q_bar(q_bar),
    .err  (err)
  );

  assign last_grant = last_grant_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Directed bench for ff_bank_arbiter; a second 6-cell instance exercises out-of-range addresses.
module tb_ff_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;

  logic       a_valid = 0, a_data = 0, a_lock = 0;
  logic       b_valid = 0, b_data = 0, b_lock = 0;
  logic [1:0] a_op = 0, b_op = 0;
  logic [2:0] a_addr = 0, b_addr = 0;
  logic       a_ready, b_ready, last_grant, busy, err;
  logic [7:0] q, q_bar;

  logic       c_a_valid = 0, c_a_data = 0;
  logic [1:0] c_a_op = 0;
  logic [2:0] c_a_addr = 0;
  logic       c_a_ready, c_b_ready, c_last_grant, c_busy, c_err;
  logic [5:0] c_q, c_q_bar;

  always #5 clk = ~clk;

  ff_bank_arbiter #(.N_CELLS(8), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_addr(a_addr),
    .a_data(a_data), .a_lock(a_lock),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_addr(b_addr),
    .b_data(b_data), .b_lock(b_lock),
    .q(q), .q_bar(q_bar), .last_grant(last_grant), .busy(busy), .err(err)
  );

  ff_bank_arbiter #(.N_CELLS(6), .MAX_HOLD(4)) u_dut6 (
    .clk(clk), .rst(rst),
    .a_valid(c_a_valid), .a_ready(c_a_ready), .a_op(c_a_op), .a_addr(c_a_addr),
    .a_data(c_a_data), .a_lock(1'b0),
    .b_valid(1'b0), .b_ready(c_b_ready), .b_op(2'b00), .b_addr(3'd0),
    .b_data(1'b0), .b_lock(1'b0),
    .q(c_q), .q_bar(c_q_bar), .last_grant(c_last_grant), .busy(c_busy), .err(c_err)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_q_bar: got %h want ff", q_bar); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant: got %b want 1", last_grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b0;
    cyc();
    $display("reset done");
  endtask

  task automatic test_load_a();
    a_valid = 1; a_op = 2'b00; a_addr = 3; a_data = 1; a_lock = 0;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL load_a_ready: got %b want 1", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL load_b_ready: got %b want 0", b_ready); end
    cyc();
    a_valid = 0;
    checks++; if (q !== 8'h08) begin errors++; $display("FAIL load_q: got %h want 08", q); end
    checks++; if (q_bar !== 8'hF7) begin errors++; $display("FAIL load_q_bar: got %h want f7", q_bar); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL load_last_grant: got %b want 0", last_grant); end
    $display("A LOAD addr=3 data=1 -> q=%h", q);
  endtask

  task automatic test_alternate();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h09; exp_q[1] = 8'h89; exp_q[2] = 8'h88; exp_q[3] = 8'h88;
    // One lone B beat (clear bit 7) so the following tie goes to A.
    b_valid = 1; b_op = 2'b00; b_addr = 7; b_data = 0; b_lock = 0;
    cyc();
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL alt_pre_grant: got %b want 1", last_grant); end
    a_valid = 1; a_op = 2'b01; a_addr = 0; a_data = 1; a_lock = 0;
    b_valid = 1; b_op = 2'b00; b_addr = 7; b_data = 1; b_lock = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a_ready !== (i % 2 == 0)) begin errors++; $display("FAIL alt_a_ready[%0d]: got %b want %b", i, a_ready, (i % 2 == 0)); end
      checks++; if (b_ready !== (i % 2 == 1)) begin errors++; $display("FAIL alt_b_ready[%0d]: got %b want %b", i, b_ready, (i % 2 == 1)); end
      cyc();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL alt_q[%0d]: got %h want %h", i, q, exp_q[i]); end
      $display("alternate beat %0d granted %s q=%h", i, (i % 2 == 0) ? "A" : "B", q);
    end
    a_valid = 0;
    b_valid = 0;
  endtask

  task automatic test_lock();
    a_valid = 1; a_op = 2'b00; a_addr = 1; a_data = 1; a_lock = 1;
    b_valid = 1; b_op = 2'b00; b_addr = 2; b_data = 1; b_lock = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL lock_a_ready[%0d]: got %b want 1", i, a_ready); end
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL lock_b_ready[%0d]: got %b want 0", i, b_ready); end
      checks++; if (busy !== (i > 0)) begin errors++; $display("FAIL lock_busy[%0d]: got %b want %b", i, busy, (i > 0)); end
      cyc();
      $display("locked beat %0d granted A", i);
    end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_release_busy: got %b want 0", busy); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL lock_release_a_ready: got %b want 0", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL lock_release_b_ready: got %b want 1", b_ready); end
    cyc();
    a_valid = 0; a_lock = 0;
    b_valid = 0;
    checks++; if (q !== 8'h8E) begin errors++; $display("FAIL lock_q: got %h want 8e", q); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL lock_last_grant: got %b want 1", last_grant); end
    $display("B granted after forced release q=%h", q);
  endtask

  task automatic test_drop_valid();
    a_valid = 1; a_op = 2'b00; a_addr = 4; a_data = 1; a_lock = 1;
    cyc();
    a_valid = 0; a_lock = 0;
    b_valid = 1; b_op = 2'b00; b_addr = 5; b_data = 1; b_lock = 0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_own: got %b want 1", busy); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL drop_b_ready_own: got %b want 0", b_ready); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_idle: got %b want 0", busy); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL drop_b_ready_idle: got %b want 1", b_ready); end
    checks++; if (q !== 8'h9E) begin errors++; $display("FAIL drop_q_mid: got %h want 9e", q); end
    cyc();
    b_valid = 0;
    checks++; if (q !== 8'hBE) begin errors++; $display("FAIL drop_q: got %h want be", q); end
    $display("A dropped valid in OWN_A, B granted q=%h", q);
  endtask

  task automatic test_bulk();
    a_valid = 1; a_op = 2'b11; a_addr = 2; a_data = 1; a_lock = 0;
    cyc();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL bcast_q: got %h want ff", q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bcast_err: got %b want 0", err); end
    a_op = 2'b10;
    cyc();
    a_valid = 0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL clear_q: got %h want 00", q); end
    checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL clear_q_bar: got %h want ff", q_bar); end
    $display("BCAST then CLEAR_ALL q=%h", q);
  endtask

  task automatic test_out_of_range();
    c_a_valid = 1; c_a_op = 2'b00; c_a_addr = 7; c_a_data = 1;
    #1;
    checks++; if (c_a_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", c_a_ready); end
    cyc();
    c_a_valid = 0;
    checks++; if (c_err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", c_err); end
    checks++; if (c_q !== 6'h00) begin errors++; $display("FAIL oor_q: got %h want 00", c_q); end
    cyc();
    checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b want 0", c_err); end
    c_a_valid = 1; c_a_op = 2'b01; c_a_addr = 5; c_a_data = 1;
    cyc();
    c_a_valid = 0;
    checks++; if (c_err !== 1'b0) begin errors++; $display("FAIL inrange_err: got %b want 0", c_err); end
    checks++; if (c_q !== 6'h20) begin errors++; $display("FAIL inrange_q: got %h want 20", c_q); end
    $display("6-cell LOAD addr=7 flagged, TOGGLE addr=5 q=%h", c_q);
  endtask

  task automatic test_reset_mid_own();
    b_valid = 1; b_op = 2'b11; b_addr = 0; b_data = 1; b_lock = 1;
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_own: got %b want 1", busy); end
    rst = 1;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rstmid_b_ready: got %b want 0", b_ready); end
    cyc();
    rst = 0;
    b_valid = 0; b_lock = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rstmid_q: got %h want 00", q); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL rstmid_last_grant: got %b want 1", last_grant); end
    $display("reset during OWN_B -> IDLE q=%h", q);
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_alternate();
    test_lock();
    test_drop_valid();
    test_bulk();
    test_out_of_range();
    test_reset_mid_own();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
